// File: rtl/hazard_ctrl_md.sv
// ID-stage hazard controller: a {a3, tnew} scoreboard for EX/MA/WB plus an MDU busy counter.
// Drives the ID stall and the ID-stage forward selects, combinationally from ID inputs and state.
module hazard_ctrl_md #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic [4:0] id_a3,
  input  logic [1:0] id_tnew,
  input  logic       id_is_md,
  input  logic       id_md_start,
  input  logic       id_md_div,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  localparam logic [1:0] SelRf = 2'd0;
  localparam logic [1:0] SelEx = 2'd1;
  localparam logic [1:0] SelMa = 2'd2;
  localparam logic [1:0] SelWb = 2'd3;

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  // Scoreboard state
  logic [4:0]       ex_a3_q, ex_a3_d;
  logic [1:0]       ex_tnew_q, ex_tnew_d;
  logic [4:0]       ma_a3_q, ma_a3_d;
  logic [1:0]       ma_tnew_q, ma_tnew_d;
  logic [4:0]       wb_a3_q, wb_a3_d;
  logic [1:0]       wb_tnew_q, wb_tnew_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operand match flags
  logic rs_ex_hit, rs_ma_hit, rs_wb_hit;
  logic rt_ex_hit, rt_ma_hit, rt_wb_hit;
  logic rs_stall, rt_stall, md_stall;

  assign md_busy = (cnt_q != '0);

  always_comb begin
    rs_ex_hit = (id_rs != 5'd0) && (ex_a3_q == id_rs);
    rs_ma_hit = (id_rs != 5'd0) && (ma_a3_q == id_rs);
    rs_wb_hit = (id_rs != 5'd0) && (wb_a3_q == id_rs);
    rt_ex_hit = (id_rt != 5'd0) && (ex_a3_q == id_rt);
    rt_ma_hit = (id_rt != 5'd0) && (ma_a3_q == id_rt);
    rt_wb_hit = (id_rt != 5'd0) && (wb_a3_q == id_rt);
  end

  // WB results are always ready by ID, so only EX and MA can stall; tuse=3 means unused.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    if (id_tuse_rs != 2'd3) begin
      rs_stall = (rs_ex_hit && (id_tuse_rs < ex_tnew_q)) ||
                 (rs_ma_hit && (id_tuse_rs < ma_tnew_q));
    end
    if (id_tuse_rt != 2'd3) begin
      rt_stall = (rt_ex_hit && (id_tuse_rt < ex_tnew_q)) ||
                 (rt_ma_hit && (id_tuse_rt < ma_tnew_q));
    end
    md_stall = id_is_md && md_busy;
    stall    = rs_stall || rt_stall || md_stall;
  end

  // Only the youngest matching stage counts; an unready youngest match falls back to regfile.
  always_comb begin
    fwd_rs_sel = SelRf;
    if (rs_ex_hit) begin
      if (ex_tnew_q == 2'd0) fwd_rs_sel = SelEx;
    end else if (rs_ma_hit) begin
      if (ma_tnew_q == 2'd0) fwd_rs_sel = SelMa;
    end else if (rs_wb_hit) begin
      if (wb_tnew_q == 2'd0) fwd_rs_sel = SelWb;
    end
  end

  always_comb begin
    fwd_rt_sel = SelRf;
    if (rt_ex_hit) begin
      if (ex_tnew_q == 2'd0) fwd_rt_sel = SelEx;
    end else if (rt_ma_hit) begin
      if (ma_tnew_q == 2'd0) fwd_rt_sel = SelMa;
    end else if (rt_wb_hit) begin
      if (wb_tnew_q == 2'd0) fwd_rt_sel = SelWb;
    end
  end

  always_comb begin
    ex_a3_d   = stall ? 5'd0 : id_a3;
    ex_tnew_d = stall ? 2'd0 : id_tnew;
    ma_a3_d   = ex_a3_q;
    ma_tnew_d = (ex_tnew_q != 2'd0) ? ex_tnew_q - 2'd1 : 2'd0;
    wb_a3_d   = ma_a3_q;
    wb_tnew_d = (ma_tnew_q != 2'd0) ? ma_tnew_q - 2'd1 : 2'd0;
  end

  // A stalled start never loads, so a load can only happen with the counter already idle.
  always_comb begin
    cnt_d = cnt_q;
    if (id_md_start && !stall) begin
      cnt_d = id_md_div ? DivLoad : MultLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_a3_q   <= 5'd0;
      ex_tnew_q <= 2'd0;
      ma_a3_q   <= 5'd0;
      ma_tnew_q <= 2'd0;
      wb_a3_q   <= 5'd0;
      wb_tnew_q <= 2'd0;
      cnt_q     <= '0;
    end else begin
      ex_a3_q   <= ex_a3_d;
      ex_tnew_q <= ex_tnew_d;
      ma_a3_q   <= ma_a3_d;
      ma_tnew_q <= ma_tnew_d;
      wb_a3_q   <= wb_a3_d;
      wb_tnew_q <= wb_tnew_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Directed-vector bench for hazard_ctrl_md with hand-computed stall/forward/busy expectations.
module tb_hazard_ctrl_md;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_a3;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
  logic       id_is_md, id_md_start, id_md_div;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl_md #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_tuse_rs (id_tuse_rs),
    .id_tuse_rt (id_tuse_rt),
    .id_a3      (id_a3),
    .id_tnew    (id_tnew),
    .id_is_md   (id_is_md),
    .id_md_start(id_md_start),
    .id_md_div  (id_md_div),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [1:0] tuse_rs,
                       input logic [4:0] rt, input logic [1:0] tuse_rt,
                       input logic [4:0] a3, input logic [1:0] tnew,
                       input logic is_md, input logic start, input logic dv);
    id_rs       = rs;
    id_tuse_rs  = tuse_rs;
    id_rt       = rt;
    id_tuse_rt  = tuse_rt;
    id_a3       = a3;
    id_tnew     = tnew;
    id_is_md    = is_md;
    id_md_start = start;
    id_md_div   = dv;
    #1;
  endtask

  task automatic nop();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1;
    nop();
    check("reset_stall", stall, 0);
    check("reset_busy", md_busy, 0);
    check("reset_fwd_rs", fwd_rs_sel, 0);
    check("reset_fwd_rt", fwd_rt_sel, 0);
    tick();
    reset = 1'b0;
    tick();

    // lw $1 -> add rs=1 (tuse 1), add writes $5
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    check("lw_issue_stall", stall, 0);
    tick();
    drive(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    check("lwadd_stall_c1", stall, 1);
    tick();
    check("lwadd_stall_c2", stall, 0);
    check("lwadd_fwd_ma_notready", fwd_rs_sel, 0);
    tick();
    check("lwadd_fwd_wb", fwd_rs_sel, 3);
    flush();

    // lw $1 -> beq rs=1 (tuse 0)
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("lwbeq_stall_c1", stall, 1);
    tick();
    check("lwbeq_stall_c2", stall, 1);
    tick();
    check("lwbeq_stall_c3", stall, 0);
    check("lwbeq_fwd_wb", fwd_rs_sel, 3);
    flush();

    // ori $2 -> beq rt=2 (tuse 0)
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 2'd3, 5'd2, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("oribeq_stall_c1", stall, 1);
    check("oribeq_fwd_rt_c1", fwd_rt_sel, 0);
    tick();
    check("oribeq_stall_c2", stall, 0);
    check("oribeq_fwd_rt_ma", fwd_rt_sel, 2);
    check("oribeq_fwd_rs_none", fwd_rs_sel, 0);
    flush();

    // jal $31 (tnew 0) -> use rs=31 forwards from EX; older $31 in MA is shadowed
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd31, 2'd1, 5'd31, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("jal_stall", stall, 0);
    check("jal_fwd_rs_ex", fwd_rs_sel, 1);
    check("jal_fwd_rt_ex", fwd_rt_sel, 1);
    flush();

    // $0 destination never matches
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 2'd1, 5'd0, 2'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("zero_stall", stall, 0);
      check("zero_fwd_rs", fwd_rs_sel, 0);
      tick();
    end
    flush();

    // mult -> mflo: 5 busy/stall cycles, issue on 6th
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    check("mult_issue_stall", stall, 0);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("mult_busy", md_busy, 1);
      check("mult_stall", stall, 1);
      tick();
    end
    check("mult_done_busy", md_busy, 0);
    check("mult_done_stall", stall, 0);
    flush();

    // div -> mflo: 10 cycles
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("div_stall", stall, 1);
      tick();
    end
    check("div_done_busy", md_busy, 0);
    check("div_done_stall", stall, 0);
    flush();

    // Reset three cycles into a div window; lw $4 in flight is discarded too
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd4, 2'd0, 5'd4, 2'd0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0);
    check("middiv_busy", md_busy, 1);
    check("middiv_stall", stall, 1);
    tick();
    reset = 1'b1;
    #1;
    check("rst_busy", md_busy, 0);
    check("rst_stall", stall, 0);
    check("rst_fwd_rs", fwd_rs_sel, 0);
    check("rst_fwd_rt", fwd_rt_sel, 0);
    tick();
    reset = 1'b0;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0);
    check("post_rst_mfhi_stall", stall, 0);
    tick();
    nop();
    check("post_rst_busy", md_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_md.md
# hazard_ctrl_md

Scoreboard-based stall and forward-select controller for the ID stage of the five-stage MIPS pipeline, extended with a multi-cycle multiply/divide unit (MDU). It does not decode instructions itself. The ID decoder supplies Tuse/Tnew per instruction, and the block tracks destination register and remaining Tnew for the EX, MA and WB stages in its own shift registers. It also runs an MDU busy counter with parametrised mult/div latency and produces the ID stall and the ID-stage forward selects.

## Interface
- MULT_CYCLES, 5, cycles MDU stays busy after a mult/multu enters EX (1..2^CNT_W-1)
- DIV_CYCLES, 10, cycles MDU stays busy after a div/divu enters EX (1..2^CNT_W-1)
- CNT_W, 4, busy counter width
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- id_rs  input  5  ID-stage rs address
- id_rt  input  5  ID-stage rt address
- id_tuse_rs  input  2  cycles until rs is consumed; 3 = not used
- id_tuse_rt  input  2  cycles until rt is consumed; 3 = not used
- id_a3  input  5  ID-stage destination register; 0 = no write
- id_tnew  input  2  Tnew on entry to EX (alu/lui 1, lw 2, jal 0)
- id_is_md  input  1  ID instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
- id_md_start  input  1  ID instruction starts an MDU operation (mult/multu/div/divu)
- id_md_div  input  1  with id_md_start: 1 = divide, 0 = multiply
- stall  output  1  freeze PC/IF-ID; insert bubble into EX
- fwd_rs_sel  output  2  ID rs source: 0 regfile, 1 EX, 2 MA, 3 WB
- fwd_rt_sel  output  2  ID rt source, same encoding
- md_busy  output  1  MDU counter nonzero

## Operation
- **Scoreboard registers.** Each of EX, MA and WB holds {a3[4:0], tnew[1:0]}.
- **Clock-edge update:**
  - EX <= stall ? {0,0} : {id_a3, id_tnew}
  - MA <= {EX.a3, dec(EX.tnew)}
  - WB <= {MA.a3, dec(MA.tnew)}
  - dec saturates at 0.
- **Match.** A stage matches rs when stage.a3 == id_rs and id_rs != 0. Same for rt. An a3 of 0 never matches.
- **Data stall.** Asserted for an operand when a matching EX has tuse < EX.tnew, or a matching MA has tuse < MA.tnew. WB never causes a stall. tuse = 3 never stalls.
- **MD stall.** id_is_md & md_busy.
- **Combined stall.** stall = data stall (rs or rt) | MD stall.
- **Forward select.** Only the youngest matching stage is considered (EX, then MA, then WB):
  - If that stage has tnew == 0, the select is that stage (1/2/3).
  - Otherwise the select is 0; the value is not ready, and downstream forwarding outside this block handles it.
  - No match: 0.
- **Busy counter (CNT_W bits).**
  - Load: at the edge where id_md_start & ~stall, cnt <= id_md_div ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise, if cnt != 0, cnt <= cnt-1.
  - md_busy = (cnt != 0).
  - Load takes priority over decrement. A start cannot reach the load while busy, because it is itself an MD instruction and is stalled.

## Timing
- **Reset.** Async reset clears EX/MA/WB to {0,0} and cnt to 0. Immediately: stall=0, fwd_rs_sel=0, fwd_rt_sel=0, md_busy=0.
- **Output path.** stall and fwd_* are combinational from the current ID inputs and registered state, with zero latency. md_busy is registered state.
- **Stall length.**
  - lw→ALU use: 1 cycle.
  - lw→branch: 2 cycles.
  - ALU→branch: 1 cycle.
- **MDU busy window.** A mult entering EX at edge k gives md_busy=1 for exactly MULT_CYCLES cycles after edge k. The next MD instruction in ID issues on the first cycle with md_busy=0.
- **Simultaneous stall causes.** Data and MD stall together give a single stall. The bubble is inserted once per stalled cycle.
- **Reset mid-operation.** Reset during a busy window clears cnt immediately. Any in-flight Tnew is discarded.

## Test plan
- **lw→add.** Stimulus: lw $1 (a3=1, tnew=2) issued, then add with rs=1, tuse=1. Required: stall=1 for 1 cycle. Next cycle stall=0 and fwd_rs_sel=0 (MA tnew=1). One cycle later fwd_rs_sel=3 (WB).
- **lw→beq.** Stimulus: lw $1 followed by beq rs=1, tuse=0. Required: stall=1 for 2 cycles, then fwd_rs_sel=3.
- **ori→beq.** Stimulus: ori $2 (tnew=1) followed by beq rt=2, tuse=0. Required: stall=1 for 1 cycle, then fwd_rt_sel=2.
- **mult→mflo.** Stimulus: mult (id_md_start=1, id_md_div=0) followed by mflo (id_is_md=1). Required: md_busy and stall high for 5 cycles; mflo issues on cycle 6. Same check with div: 10 cycles.
- **$0 destination.** Stimulus: lw with a3=0 followed by add rs=0, tuse=1. Required: stall=0 and fwd_rs_sel=0 throughout.
- **Reset mid-div.** Stimulus: assert reset 3 cycles into a div busy window. Required: md_busy=0, stall=0 and all fwd_*=0 asynchronously. After release, a following mfhi issues without stall.
